regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-port controller for the `RegisterFile` in the fermi32 core. It merges results from the single-cycle ALU and the variable-latency memory/multiply unit onto the register file's single write port (`WE3`/`A3`/`WD3`). It also provides same-cycle forwarding data for the two read ports. Memory results are held in a small FIFO, and a starvation counter guarantees that the FIFO eventually drains.

## Interface
- `XLEN`, 32: data width.
- `ADDR_W`, 5: register address width.
- `DEPTH`, 2: memory-result FIFO depth, power of two, ≥2.
- `STARVE_MAX`, 4: consecutive cycles of blocked FIFO head before the ALU is stalled.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_ready`  out  1  ALU result accepted when `alu_valid && alu_ready`.
- `alu_rd`  in  ADDR_W  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`  in  1  memory result offered.
- `mem_ready`  out  1  FIFO can accept; transfer on `mem_valid && mem_ready`.
- `mem_rd`  in  ADDR_W  memory destination register.
- `mem_data`  in  XLEN  memory result.
- `WE3`  out  1  register-file write enable (registered).
- `A3`  out  ADDR_W  write address (registered).
- `WD3`  out  XLEN  write data (registered).
- `A1`, `A2`  in  ADDR_W  read addresses currently presented to the register file.
- `fwd1_hit`, `fwd2_hit`  out  1  pending write matches `A1`/`A2`.
- `fwd1_data`, `fwd2_data`  out  XLEN  forwarded value when the corresponding hit is set.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO push.** `mem_ready = (count < DEPTH)`. It depends only on the registered count, so when the FIFO is full it is not ready, even if a pop happens that cycle. An accepted transfer writes `{mem_rd, mem_data}` at the write pointer.
- **Arbitration**, evaluated each cycle with priority from top to bottom:
  1. Stall. If `starve == STARVE_MAX` and `count > 0`: `alu_ready = 0`, the FIFO head is popped into the write stage, and `starve` is cleared.
  2. ALU write. Else if `alu_valid`: the ALU entry goes to the write stage. If `count > 0`, `starve` increments, saturating at `STARVE_MAX`.
  3. FIFO drain. Else if `count > 0`: the head is popped into the write stage and `starve` is cleared.
  4. Idle. Otherwise the write stage loads `WE3 = 0`.
- **Starvation counter.** `starve` is cleared whenever `count == 0`.
- **x0 suppression.** An entry with `rd == 0` is consumed (handshake completes, pop occurs) but loads `WE3 = 0`. `A3` and `WD3` still take the entry's values.
- **Forwarding.** `fwdN_hit = WE3 && (A3 == AN) && (AN != 0)`, and `fwdN_data = WD3`. This is combinational from the registered write stage and covers the register file's write-then-read edge.
- **Pointers.** Read and write pointers wrap modulo `DEPTH`. A push and a pop in the same cycle leave `count` unchanged.

## Timing
- **Reset values:** `WE3 = 0`, `A3 = 0`, `WD3 = 0`, `count = 0`, pointers = 0, `starve = 0`. Consequently `alu_ready = 1`, `mem_ready = 1`, `pending = 0`, and both hit outputs are 0.
- **ALU latency:** 1 cycle. Accepted at edge N, `WE3`/`A3`/`WD3` are valid during cycle N+1, and the register file commits at edge N+1.
- **Memory latency:** at least 2 cycles. There is no FIFO bypass; a pushed entry can be popped no earlier than the following cycle.
- **Ordering:** memory results commit in acceptance order. No ordering is guaranteed between ALU and memory results to the same `rd`. The issue logic must avoid such WAW hazards.
- **`alu_ready`** is combinational from registered `starve` and `count` only. It never depends on `alu_valid`.
- **Reset mid-operation:** FIFO contents are discarded, and any in-flight `WE3` drops asynchronously.

## Structure
- **`fermi32_pkg`** holds:
  - `XLEN`, `REG_ADDR_W`;
  - `typedef struct packed { logic [REG_ADDR_W-1:0] rd; logic [XLEN-1:0] data; } wb_entry_t`.
- **Sub-module `wb_fifo`:** parameterized `DEPTH` with a `wb_entry_t` payload. It has push/pop/count and no internal bypass.
- **Top level** contains the arbiter, the starvation counter, the write-stage registers and the forwarding compare.

## Test plan
- **Reset:** assert `rst` mid-cycle with FIFO count 2 → `WE3 = 0` immediately; after release `pending = 0` and `mem_ready = 1`.
- **ALU write:** `alu_valid`, `rd = 5`, data `0xDEADBEEF` → next cycle `WE3 = 1`, `A3 = 5`, `WD3 = 0xDEADBEEF`; with `A1 = 5`, `fwd1_hit = 1` and `fwd1_data = 0xDEADBEEF`.
- **FIFO full:** two memory pushes (`rd = 7`, then `rd = 8`) while the ALU is busy → `mem_ready = 0`. After the ALU goes idle, writes to 7 then 8 follow on consecutive cycles.
- **Starvation:** ALU valid every cycle with one FIFO entry (`rd = 9`, `0x1234`) → after 4 ALU writes `alu_ready = 0` for one cycle; next cycle `A3 = 9`, `WD3 = 0x1234`.
- **x0 suppression:** memory entry with `rd = 0`, data `0xFFFF_FFFF` → handshake completes, `pending` decrements, `WE3` stays 0, and `fwd2_hit = 0` with `A2 = 0`.
- **Wrap-around:** 10 back-to-back memory pushes with the ALU idle → writes appear in order with `rd` 1..10, with no loss and no duplicates.

Source files
------------

// File: rtl/fermi32_pkg.sv
// Shared types for the fermi32 core: register-file geometry and the writeback entry.
package fermi32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Memory-result FIFO for the writeback port; registered head, no push-to-pop bypass.
module wb_fifo
    import fermi32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Storage is left unreset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/regfile_writeback.sv
// Single write-port arbiter for the register file: ALU first, FIFO'd memory results
// drained when idle or when the starvation counter forces an ALU stall.
module regfile_writeback
    import fermi32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4,
    localparam int CW        = $clog2(DEPTH) + 1,
    localparam int SW        = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [XLEN-1:0]   WD3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic [XLEN-1:0]   fwd2_data,
    output logic [CW-1:0]     pending
);

    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic          has_data;
    logic          stall;
    logic          push;
    logic          pop;
    logic          sel_vld;
    wb_entry_t     sel;
    wb_entry_t     head;
    wb_entry_t     mem_in;

    assign has_data = (count != '0);
    assign stall    = (starve == SW'(STARVE_MAX)) && has_data;

    // Both handshakes look only at registered state, never at the valids.
    assign alu_ready = !stall;
    assign mem_ready = (count < CW'(DEPTH));
    assign push      = mem_valid && mem_ready;
    assign pop       = stall || (!alu_valid && has_data);
    assign pending   = count;

    assign mem_in.rd   = mem_rd;
    assign mem_in.data = mem_data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (mem_in),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_comb begin
        sel_vld = 1'b0;
        sel     = head;
        if (stall) begin
            sel_vld = 1'b1;
        end else if (alu_valid) begin
            sel_vld  = 1'b1;
            sel.rd   = alu_rd;
            sel.data = alu_data;
        end else if (has_data) begin
            sel_vld = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve <= '0;
        else if (!has_data || stall)
            starve <= '0;
        else if (alu_valid)
            starve <= (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
        else
            starve <= '0;
    end

    // Entries to x0 still complete their handshake but never assert the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else if (sel_vld) begin
            WE3 <= (sel.rd != '0);
            A3  <= sel.rd;
            WD3 <= sel.data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    assign fwd1_hit  = WE3 && (A3 == A1) && (A1 != '0);
    assign fwd2_hit  = WE3 && (A3 == A2) && (A2 != '0);
    assign fwd1_data = WD3;
    assign fwd2_data = WD3;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed test of regfile_writeback: reset, ALU path, FIFO full, starvation, x0, wrap.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  A1, A2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [1:0]  pending;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_writeback #(.XLEN(32), .ADDR_W(5), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .WE3(WE3), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    initial begin
        idle_in();
        A1 = '0; A2 = '0;
        rst = 1'b1;
        #12;
        chk("rst_we3", WE3, 0);
        chk("rst_a3", A3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_pending", pending, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_hits", {fwd1_hit, fwd2_hit}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // ALU write with forwarding; A2 also matches nothing because it is 0
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; A1 = 5'd5; A2 = 5'd0;
        step();
        alu_valid = 1'b0;
        chk("alu_we3", WE3, 1);
        chk("alu_a3", A3, 5);
        chk("alu_wd3", WD3, 32'hDEADBEEF);
        chk("alu_fwd1_hit", fwd1_hit, 1);
        chk("alu_fwd1_data", fwd1_data, 32'hDEADBEEF);
        chk("alu_fwd2_hit", fwd2_hit, 0);
        step();
        chk("alu_idle_we3", WE3, 0);
        chk("alu_idle_fwd1", fwd1_hit, 0);
        A1 = '0;

        // FIFO full while the ALU keeps the port busy
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h700;
        step();
        chk("full_pend1", pending, 1);
        chk("full_mrdy1", mem_ready, 1);
        mem_rd = 5'd8; mem_data = 32'h800;
        step();
        mem_valid = 1'b0;
        chk("full_pend2", pending, 2);
        chk("full_mrdy0", mem_ready, 0);
        chk("full_alu_a3", A3, 3);
        alu_valid = 1'b0;
        step();
        chk("full_drain7_a3", A3, 7);
        chk("full_drain7_wd3", WD3, 32'h700);
        chk("full_drain7_we3", WE3, 1);
        step();
        chk("full_drain8_a3", A3, 8);
        chk("full_drain8_wd3", WD3, 32'h800);
        step();
        chk("full_empty_we3", WE3, 0);
        chk("full_empty_pend", pending, 0);

        // Mid-cycle reset with two entries queued and a write in flight
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hB;
        step();
        mem_rd = 5'd12; mem_data = 32'hC;
        step();
        idle_in();
        chk("rstmid_pre_pend", pending, 2);
        chk("rstmid_pre_we3", WE3, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_we3", WE3, 0);
        chk("rstmid_pend", pending, 0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rstmid_mrdy", mem_ready, 1);
        step();
        chk("rstmid_post_we3", WE3, 0);
        chk("rstmid_post_pend", pending, 0);

        // Starvation: one queued entry, ALU valid every cycle
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'd20;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h1234;
        step();
        mem_valid = 1'b0;
        chk("starve_a3_20", A3, 20);
        chk("starve_pend", pending, 1);
        for (int k = 1; k <= 4; k++) begin
            alu_rd = 5'(20 + k); alu_data = 32'(20 + k);
            step();
            chk("starve_alu_a3", A3, 64'(20 + k));
            chk("starve_alu_ready", alu_ready, (k == 4) ? 64'd0 : 64'd1);
        end
        alu_rd = 5'd25; alu_data = 32'd25;
        step();
        chk("starve_pop_a3", A3, 9);
        chk("starve_pop_wd3", WD3, 32'h1234);
        chk("starve_pop_pend", pending, 0);
        chk("starve_ready_back", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        chk("starve_held_a3", A3, 25);
        step();

        // x0 suppression
        A2 = 5'd0;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
        step();
        mem_valid = 1'b0;
        chk("x0_pend1", pending, 1);
        step();
        chk("x0_pend0", pending, 0);
        chk("x0_we3", WE3, 0);
        chk("x0_wd3", WD3, 32'hFFFF_FFFF);
        chk("x0_fwd2", fwd2_hit, 0);

        // Wrap-around: ten back-to-back pushes, ALU idle
        for (int i = 1; i <= 10; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(i); mem_data = 32'(32'h100 + i);
            step();
            chk("wrap_mrdy", mem_ready, 1);
            if (i > 1) begin
                chk("wrap_a3", A3, 64'(i - 1));
                chk("wrap_wd3", WD3, 64'(32'h100 + i - 1));
                chk("wrap_we3", WE3, 1);
            end
        end
        mem_valid = 1'b0;
        step();
        chk("wrap_last_a3", A3, 10);
        chk("wrap_last_wd3", WD3, 32'h10A);
        step();
        chk("wrap_done_we3", WE3, 0);
        chk("wrap_done_pend", pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
